// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, the "no register"
// id and the pipeline-control FSM state encoding.
package y86_pkg;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Performance counters for pipe_ctrl; only present when PIPE_PERF_CNT_EN is defined.
// All counters wrap modulo 2^CNT_W, clear on reset and freeze once HALTED.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  pipe_state_e      state_i,
  input  logic             f_stall_i,
  input  logic             e_bubble_i,
  input  logic [2:0]       w_stat_i,
  input  logic [3:0]       w_icode_i,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] ret_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bub_cnt_o
);

  logic [CNT_W-1:0] cyc_q, ret_q, stall_q, bub_q;
  logic             live, in_run;

  assign live   = (state_i != ST_HALTED);
  assign in_run = (state_i == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      ret_q   <= '0;
      stall_q <= '0;
      bub_q   <= '0;
    end else begin
      if (live) cyc_q <= cyc_q + 1'b1;
      if (live && w_stat_i == SAOK && w_icode_i != INOP) ret_q <= ret_q + 1'b1;
      if (in_run && f_stall_i) stall_q <= stall_q + 1'b1;
      if (in_run && e_bubble_i) bub_q <= bub_q + 1'b1;
    end
  end

  assign cyc_cnt_o   = cyc_q;
  assign ret_cnt_o   = ret_q;
  assign stall_cnt_o = stall_q;
  assign bub_cnt_o   = bub_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: combinational hazard stall/bubble plus a RUN/DRAIN/HALTED
// FSM that freezes the core once a bad status retires. PIPE_PERF_CNT_EN adds counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       final_stat,
  output logic [1:0]       dbg_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bub_cnt
`endif
);

  pipe_state_e state_q, state_d;
  logic [2:0]  final_stat_q, final_stat_d;
  logic        loaduse, ret, mispred, mexc, wexc;

  assign loaduse = (E_icode == IMRMOVQ || E_icode == IPOPQ) && (E_dstM != RNONE) &&
                   (E_dstM == d_srcA || E_dstM == d_srcB);
  assign ret     = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mispred = (E_icode == IJXX) && !e_Cnd;
  assign mexc    = (m_stat != SAOK);
  assign wexc    = (W_stat != SAOK);

  // A write-back exception wins over a memory one: the core halts straight from RUN.
  always_comb begin
    F_stall      = loaduse | ret;
    D_stall      = loaduse;
    D_bubble     = mispred | (ret & !loaduse);
    E_bubble     = mispred | loaduse;
    M_bubble     = mexc | wexc;
    W_stall      = wexc;
    set_cc       = (E_icode == IOPQ) & !mexc & !wexc;
    state_d      = state_q;
    final_stat_d = final_stat_q;
    case (state_q)
      ST_RUN: begin
        if (wexc) begin
          state_d      = ST_HALTED;
          final_stat_d = W_stat;
        end else if (mexc) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        F_stall  = 1'b1;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        set_cc   = 1'b0;
        if (wexc) begin
          state_d      = ST_HALTED;
          final_stat_d = W_stat;
        end
      end
      ST_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
    if (reset) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b0;
      set_cc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      final_stat_q <= SAOK;
    end else begin
      state_q      <= state_d;
      final_stat_q <= final_stat_d;
    end
  end

  assign halted     = (state_q == ST_HALTED);
  assign final_stat = final_stat_q;
  assign dbg_state  = state_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk        (clk),
    .reset      (reset),
    .state_i    (state_q),
    .f_stall_i  (F_stall),
    .e_bubble_i (E_bubble),
    .w_stat_i   (W_stat),
    .w_icode_i  (W_icode),
    .cyc_cnt_o  (cyc_cnt),
    .ret_cnt_o  (ret_cnt),
    .stall_cnt_o(stall_cnt),
    .bub_cnt_o  (bub_cnt)
  );
`else
  // W_icode and CNT_W only feed the counters.
  logic             unused_w_icode;
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_w_icode = ^W_icode;
  assign unused_cnt_w   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard vectors, exception drain/halt, reset recovery
// and (with PIPE_PERF_CNT_EN) counter wrap at CNT_W=4.
module tb_pipe_ctrl;
  import y86_pkg::*;

`ifdef PIPE_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic             e_Cnd;
  logic [2:0]       m_stat, W_stat;
  logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [2:0]       final_stat;
  logic [1:0]       dbg_state;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt, bub_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .D_icode   (D_icode),
    .d_srcA    (d_srcA),
    .d_srcB    (d_srcB),
    .E_icode   (E_icode),
    .E_dstM    (E_dstM),
    .e_Cnd     (e_Cnd),
    .M_icode   (M_icode),
    .m_stat    (m_stat),
    .W_icode   (W_icode),
    .W_stat    (W_stat),
    .F_stall   (F_stall),
    .D_stall   (D_stall),
    .D_bubble  (D_bubble),
    .E_bubble  (E_bubble),
    .M_bubble  (M_bubble),
    .W_stall   (W_stall),
    .set_cc    (set_cc),
    .halted    (halted),
    .final_stat(final_stat),
    .dbg_state (dbg_state)
`ifdef PIPE_PERF_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt),
    .stall_cnt (stall_cnt),
    .bub_cnt   (bub_cnt)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // drivers: inputs change 1 time unit after posedge, outputs sampled at negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    D_icode = INOP; d_srcA = 4'h0; d_srcB = 4'h0;
    E_icode = INOP; E_dstM = RNONE; e_Cnd = 1'b1;
    M_icode = INOP; m_stat = SAOK;
    W_icode = INOP; W_stat = SAOK;
  endtask

  // outputs packed as {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
  function automatic logic [6:0] outs();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // reset state
    sample();
    check_eq("reset_outs", outs(), 7'b0011100);
    tick();
    sample();
    check_eq("reset_halted", halted, 1'b0);
    check_eq("reset_final_stat", final_stat, SAOK);
    check_eq("reset_state", dbg_state, ST_RUN);
    reset = 1'b0;
    tick();
    sample();
    check_eq("idle_outs", outs(), 7'b0000000);

    // load/use: mrmovq into srcA
    tick(); E_icode = IMRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
    sample(); check_eq("loaduse_mrmov_srcA", outs(), 7'b1101000);
    // load/use: popq into srcB
    tick(); idle(); E_icode = IPOPQ; E_dstM = 4'h4; d_srcB = 4'h4;
    sample(); check_eq("loaduse_pop_srcB", outs(), 7'b1101000);
    // no hazard when dstM is RNONE even if a source is RNONE
    tick(); idle(); E_icode = IMRMOVQ; E_dstM = RNONE; d_srcA = RNONE;
    sample(); check_eq("loaduse_rnone", outs(), 7'b0000000);
    // load/use beats ret in D
    tick(); idle(); E_icode = IMRMOVQ; E_dstM = 4'h2; d_srcA = 4'h2; D_icode = IRET;
    sample(); check_eq("loaduse_over_ret", outs(), 7'b1101000);

    // ret walking through D, E, M
    tick(); idle(); D_icode = IRET;
    sample(); check_eq("ret_in_D", outs(), 7'b1010000);
    tick(); idle(); E_icode = IRET;
    sample(); check_eq("ret_in_E", outs(), 7'b1010000);
    tick(); idle(); M_icode = IRET;
    sample(); check_eq("ret_in_M", outs(), 7'b1010000);
    tick(); idle();
    sample(); check_eq("ret_done", outs(), 7'b0000000);

    // mispredicted jump with ret in D
    tick(); idle(); E_icode = IJXX; e_Cnd = 1'b0; D_icode = IRET;
    sample(); check_eq("mispred_ret", outs(), 7'b1011000);
    tick(); idle(); E_icode = IJXX; e_Cnd = 1'b1;
    sample(); check_eq("jxx_taken", outs(), 7'b0000000);
    tick(); idle(); E_icode = IOPQ;
    sample(); check_eq("opq_set_cc", outs(), 7'b0000001);

    // memory exception -> DRAIN
    tick(); idle(); E_icode = IOPQ; m_stat = SADR;
    sample();
    check_eq("mexc_run_outs", outs(), 7'b0000100);
    check_eq("mexc_run_state", dbg_state, ST_RUN);
    tick(); idle(); E_icode = IOPQ; E_dstM = 4'h1; d_srcA = 4'h1; E_icode = IMRMOVQ;
    sample();
    check_eq("drain_state", dbg_state, ST_DRAIN);
    check_eq("drain_outs", outs(), 7'b1011000);
    check_eq("drain_halted", halted, 1'b0);
    tick(); idle(); E_icode = IOPQ; W_stat = SADR;
    sample();
    check_eq("drain_wexc_outs", outs(), 7'b1011110);
    check_eq("drain_wexc_state", dbg_state, ST_DRAIN);
    tick(); idle(); E_icode = IMRMOVQ; E_dstM = 4'h1; d_srcA = 4'h1;
    sample();
    check_eq("halt_state", dbg_state, ST_HALTED);
    check_eq("halt_halted", halted, 1'b1);
    check_eq("halt_final_stat", final_stat, SADR);
    check_eq("halt_outs", outs(), 7'b1011110);
    tick(); idle(); W_stat = SINS; E_icode = IOPQ;
    sample();
    check_eq("halt_sticky", halted, 1'b1);
    check_eq("halt_final_keep", final_stat, SADR);
    check_eq("halt_sticky_outs", outs(), 7'b1011110);

    // reset out of HALTED
    tick(); idle(); reset = 1'b1;
    sample();
    check_eq("rst_in_halt_outs", outs(), 7'b0011100);
    check_eq("rst_in_halt_still", halted, 1'b1);
    tick(); reset = 1'b0;
    sample();
    check_eq("rst_halt_halted", halted, 1'b0);
    check_eq("rst_halt_final", final_stat, SAOK);
    check_eq("rst_halt_state", dbg_state, ST_RUN);
    check_eq("rst_halt_outs", outs(), 7'b0000000);

    // write-back exception straight from RUN
    tick(); idle(); W_stat = SHLT; E_icode = IOPQ;
    sample(); check_eq("wexc_run_outs", outs(), 7'b0000110);
    tick(); idle();
    sample();
    check_eq("wexc_run_halted", halted, 1'b1);
    check_eq("wexc_run_final", final_stat, SHLT);

    // reset mid-drain
    do_reset();
    tick(); idle(); m_stat = SINS;
    tick(); idle(); reset = 1'b1;
    sample(); check_eq("rst_drain_pre", dbg_state, ST_DRAIN);
    tick(); reset = 1'b0;
    sample(); check_eq("rst_drain_state", dbg_state, ST_RUN);

`ifdef PIPE_PERF_CNT_EN
    // counters: 3 load/use cycles then 14 retiring cycles = 17 RUN cycles
    do_reset();
    sample();
    check_eq("cnt_cleared", {cyc_cnt, ret_cnt, stall_cnt, bub_cnt}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      idle(); E_icode = IMRMOVQ; E_dstM = 4'h5; d_srcB = 4'h5;
      tick();
    end
    for (int i = 0; i < 14; i++) begin
      idle(); W_icode = IOPQ;
      tick();
    end
    idle();
    sample();
    check_eq("cyc_cnt_wrap", cyc_cnt, 4'd1);
    check_eq("ret_cnt", ret_cnt, 4'd14);
    check_eq("stall_cnt", stall_cnt, 4'd3);
    check_eq("bub_cnt", bub_cnt, 4'd3);
    // halt then confirm counters freeze
    W_stat = SHLT;
    tick(); idle(); W_icode = IOPQ;
    tick(); tick();
    sample();
    check_eq("cyc_cnt_freeze", cyc_cnt, 4'd2);
    check_eq("ret_cnt_freeze", ret_cnt, 4'd14);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
